// File: rtl/hazard3_fetch_aligner.sv
// Fetch aligner: buffers up to four halfwords from word-aligned fetches and
// presents a 16- or 32-bit instruction window to the decompressor.
module hazard3_fetch_aligner #(
    parameter int EXTENSION_C = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_data,
    input  logic        fetch_data_vld,
    input  logic        fetch_err,
    output logic        fetch_data_rdy,
    input  logic        flush,
    input  logic        flush_addr_hw,
    output logic [31:0] instr_out,
    output logic        instr_vld,
    output logic        instr_err,
    input  logic        instr_rdy,
    output logic [2:0]  level
);

    localparam logic EXT_C = (EXTENSION_C != 0);

    function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [15:0] hw_data_q [4];
    logic [15:0] hw_data_d [4];
    logic [3:0]  hw_err_q, hw_err_d;
    logic [2:0]  level_q, level_d;
    logic        discard_q, discard_d;

    logic [15:0] hw0_vis, hw1_vis;
    logic        err0_vis, err1_vis;
    logic        is32;
    logic [2:0]  need;
    logic [2:0]  pop_cnt, push_cnt;
    logic        push;
    logic [2:0]  wr_base;
    logic [1:0]  wr0, wr1;

    // Entries beyond the current level are stale and must read as zero.
    assign hw0_vis  = (level_q >= 3'd1) ? hw_data_q[0] : 16'h0000;
    assign hw1_vis  = (level_q >= 3'd2) ? hw_data_q[1] : 16'h0000;
    assign err0_vis = (level_q >= 3'd1) & hw_err_q[0];
    assign err1_vis = (level_q >= 3'd2) & hw_err_q[1];

    assign is32 = !EXT_C || (hw0_vis[1:0] == 2'b11);
    assign need = is32 ? 3'd2 : 3'd1;

    assign instr_vld      = !flush && (level_q != 3'd0) && ((level_q >= need) || err0_vis);
    assign instr_out      = {hw1_vis, hw0_vis};
    assign instr_err      = err0_vis | (is32 & err1_vis);
    assign fetch_data_rdy = !flush && (level_q <= 3'd2);
    assign level          = level_q;

    assign pop_cnt  = (instr_vld && instr_rdy) ? min3(need, level_q) : 3'd0;
    assign push     = fetch_data_vld && fetch_data_rdy;
    assign push_cnt = !push ? 3'd0 : (discard_q ? 3'd1 : 3'd2);

    // Push lands after the entries that survive this cycle's pop; level<=2 on push keeps wr1 in range.
    assign wr_base = level_q - pop_cnt;
    assign wr0     = wr_base[1:0];
    assign wr1     = wr0 + 2'd1;

    always_comb begin
        hw_data_d = hw_data_q;
        hw_err_d  = hw_err_q;
        level_d   = level_q - pop_cnt + push_cnt;
        discard_d = discard_q;

        case (pop_cnt)
            3'd1: begin
                hw_data_d[0] = hw_data_q[1];
                hw_data_d[1] = hw_data_q[2];
                hw_data_d[2] = hw_data_q[3];
                hw_err_d[2:0] = hw_err_q[3:1];
            end
            3'd2: begin
                hw_data_d[0] = hw_data_q[2];
                hw_data_d[1] = hw_data_q[3];
                hw_err_d[1:0] = hw_err_q[3:2];
            end
            default: ;
        endcase

        if (push) begin
            if (discard_q) begin
                hw_data_d[wr0] = fetch_data[31:16];
                hw_err_d[wr0]  = fetch_err;
                discard_d      = 1'b0;
            end else begin
                hw_data_d[wr0] = fetch_data[15:0];
                hw_err_d[wr0]  = fetch_err;
                hw_data_d[wr1] = fetch_data[31:16];
                hw_err_d[wr1]  = fetch_err;
            end
        end

        // A redirect to an odd halfword means the low half of the next word is skipped.
        if (flush) begin
            level_d   = 3'd0;
            discard_d = flush_addr_hw & EXT_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hw_data_q <= '{default: 16'h0000};
            hw_err_q  <= 4'h0;
            level_q   <= 3'd0;
            discard_q <= 1'b0;
        end else begin
            hw_data_q <= hw_data_d;
            hw_err_q  <= hw_err_d;
            level_q   <= level_d;
            discard_q <= discard_d;
        end
    end

endmodule
